// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, command bytes
// and the parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE,
    ST_ERR
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 CLK and DAT pins plus a registered
// strobe marking each synchronised CLK 1->0 transition. Idle lines read high,
// so the flops reset to 1 and no false edge appears after reset.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic       r_clk_prev;
  logic       r_fall;

  // Synchronise both pins, remember the previous CLK sample and register the fall strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta     <= 2'b11;
      r_sync     <= 2'b11;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_meta     <= {ps2_dat_in, ps2_clk_in};
      r_sync     <= r_meta;
      r_clk_prev <= r_sync[0];
      r_fall     <= r_clk_prev & ~r_sync[0];
    end
  end

  assign clk_sync = r_sync[0];
  assign dat_sync = r_sync[1];
  assign clk_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues a request-to-send,
// then shifts one byte, odd parity and stop out on the device's falling clock
// edges and samples the device ACK. Lines are driven through drive-low enables;
// the tristate buffers live at the chip top.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PACKET_TIMEOUT = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_CLK_in,
  input  logic       PS2_DAT_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_P = (MAX_A > PACKET_TIMEOUT) ? MAX_A : PACKET_TIMEOUT;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] PKT_LAST   = CW'(PACKET_TIMEOUT - 1);

  logic w_clk_sync;
  logic w_dat_sync;
  logic w_clk_fall;

  ps2_line_sync u_sync (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk_in (PS2_CLK_in),
    .ps2_dat_in (PS2_DAT_in),
    .clk_sync   (w_clk_sync),
    .dat_sync   (w_dat_sync),
    .clk_fall   (w_clk_fall)
  );

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
  logic [2:0]      r_bit, w_bit_next, w_bit_inc;
  logic [7:0]      r_data, w_data_next;
  logic            r_par, w_par_next;
  logic            r_clk_dl, w_clk_dl_next;
  logic            r_dat_dl, w_dat_dl_next;
  logic            r_ack, w_ack_next;
  logic            r_done, w_done_next;
  logic            r_err, w_err_next;
  logic            r_tx_ready, r_rx_inhibit;
  logic            w_go_err;
  logic            w_pkt_expired;

  // One shared counter: inhibit time, start timeout, then packet timeout. Saturates.
  assign w_cnt_inc     = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_bit_inc     = r_bit + 3'd1;
  assign w_pkt_expired = (r_cnt >= PKT_LAST);

  // Next-state and next-output logic; a timeout is checked before the fall strobe.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = w_cnt_inc;
    w_bit_next    = r_bit;
    w_data_next   = r_data;
    w_par_next    = r_par;
    w_clk_dl_next = r_clk_dl;
    w_dat_dl_next = r_dat_dl;
    w_ack_next    = r_ack;
    w_done_next   = 1'b0;
    w_err_next    = 1'b0;
    w_go_err      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_next    = '0;
        w_clk_dl_next = 1'b0;
        w_dat_dl_next = 1'b0;
        if (tx_valid && r_tx_ready) begin
          w_data_next   = tx_data;
          w_par_next    = odd_parity(tx_data);
          w_ack_next    = 1'b0;
          w_clk_dl_next = 1'b1;
          w_state_next  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt >= INH_LAST) begin
          w_dat_dl_next = 1'b1;
          w_clk_dl_next = 1'b0;
          w_cnt_next    = '0;
          w_state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (r_cnt >= START_LAST) begin
          w_go_err = 1'b1;
        end else if (w_clk_fall) begin
          w_bit_next    = 3'd0;
          w_dat_dl_next = ~r_data[0];
          w_cnt_next    = '0;
          w_state_next  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_pkt_expired) begin
          w_go_err = 1'b1;
        end else if (w_clk_fall) begin
          if (r_bit == 3'd7) begin
            w_dat_dl_next = ~r_par;
            w_state_next  = ST_PARITY;
          end else begin
            w_bit_next    = w_bit_inc;
            w_dat_dl_next = ~r_data[w_bit_inc];
          end
        end
      end
      ST_PARITY: begin
        if (w_pkt_expired) begin
          w_go_err = 1'b1;
        end else if (w_clk_fall) begin
          w_dat_dl_next = 1'b0;
          w_state_next  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_pkt_expired) begin
          w_go_err = 1'b1;
        end else if (w_clk_fall) begin
          w_ack_next   = ~w_dat_sync;
          w_state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_sync && w_dat_sync) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        w_clk_dl_next = 1'b0;
        w_dat_dl_next = 1'b0;
        w_state_next  = ST_IDLE;
      end
      default: begin
        w_clk_dl_next = 1'b0;
        w_dat_dl_next = 1'b0;
        w_state_next  = ST_IDLE;
      end
    endcase

    if (w_go_err) begin
      w_clk_dl_next = 1'b0;
      w_dat_dl_next = 1'b0;
      w_err_next    = 1'b1;
      w_state_next  = ST_ERR;
    end
  end

  // State and registered outputs; tx_ready/rx_inhibit follow the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_data       <= 8'd0;
      r_par        <= 1'b0;
      r_clk_dl     <= 1'b0;
      r_dat_dl     <= 1'b0;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_rx_inhibit <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_data       <= w_data_next;
      r_par        <= w_par_next;
      r_clk_dl     <= w_clk_dl_next;
      r_dat_dl     <= w_dat_dl_next;
      r_ack        <= w_ack_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_tx_ready   <= (w_state_next == ST_IDLE);
      r_rx_inhibit <= (w_state_next != ST_IDLE);
    end
  end

  assign tx_ready          = r_tx_ready;
  assign rx_inhibit        = r_rx_inhibit;
  assign ps2_clk_drive_low = r_clk_dl;
  assign ps2_dat_drive_low = r_dat_dl;
  assign done              = r_done;
  assign ack_ok            = r_ack;
  assign error             = r_err;

endmodule
